// File: rtl/data_mem_responder.sv
// Single-port data memory slave: one request at a time, fixed response latency,
// range/alignment checking and byte or word access.
module data_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        req,
   input  logic        we,
   input  logic        byteop,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned IW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic        byteop_q;
   logic [31:0] mem [MEM_WORDS];

   logic          accept;
   logic          do_op;
   logic          op_we;
   logic          op_byte;
   logic [31:0]   op_addr;
   logic [31:0]   op_wdata;
   logic [31:0]   offset;
   logic [IW-1:0] idx;
   logic [1:0]    lane;
   logic          op_err;
   logic [31:0]   word;

   // With no wait cycles the access completes on the accepting edge, so it must
   // use the live inputs rather than the captured copies.
   always_comb begin
      accept   = Reset && (state == StIdle) && req;
      do_op    = Reset && ((accept && (WAIT_CYCLES == 0)) ||
                           ((state == StWait) && (cnt == 4'd0)));
      op_we    = (state == StIdle) ? we     : we_q;
      op_byte  = (state == StIdle) ? byteop : byteop_q;
      op_addr  = (state == StIdle) ? addr   : addr_q;
      op_wdata = (state == StIdle) ? wdata  : wdata_q;
      offset   = op_addr - BASE_ADDR;
      idx      = offset[IW+1:2];
      lane     = op_addr[1:0];
      op_err   = (|(offset >> (IW + 2))) || (!op_byte && (lane != 2'd0));
      word     = mem[idx];
   end

   // Memory is deliberately left out of reset.
   always_ff @(posedge CLK) begin
      if (do_op && op_we && !op_err) begin
         if (op_byte) begin
            mem[idx][{lane, 3'b000} +: 8] <= op_wdata[7:0];
         end else begin
            mem[idx] <= op_wdata;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state <= StIdle;
         cnt   <= 4'd0;
         ack   <= 1'b0;
         err   <= 1'b0;
         rdata <= 32'd0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         if (do_op) begin
            ack <= 1'b1;
            err <= op_err;
            if (op_err) begin
               rdata <= 32'd0;
            end else if (!op_we) begin
               rdata <= op_byte ? {24'd0, word[{lane, 3'b000} +: 8]} : word;
            end
         end
         unique case (state)
            StIdle: begin
               if (req) begin
                  addr_q   <= addr;
                  wdata_q  <= wdata;
                  we_q     <= we;
                  byteop_q <= byteop;
                  if (WAIT_CYCLES == 0) begin
                     state <= StResp;
                  end else begin
                     state <= StWait;
                     cnt   <= 4'(WAIT_CYCLES - 1);
                  end
               end
            end
            StWait: begin
               if (cnt == 4'd0) begin
                  state <= StResp;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            StResp:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: transaction-level model checked every
// cycle, plus directed cases with literal expectations.
module tb_data_mem_responder;

   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam int unsigned MW   = 1024;
   localparam int unsigned W    = 2;

   logic        clk = 1'b0;
   logic        rst_n, rst0_n;
   logic        req, req0, we, byteop;
   logic [31:0] addr, wdata;
   logic        ack, err, ack0, err0;
   logic [31:0] rdata, rdata0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(MW), .WAIT_CYCLES(W)) dut (
      .CLK(clk), .Reset(rst_n), .req(req), .we(we), .byteop(byteop), .addr(addr),
      .wdata(wdata), .ack(ack), .rdata(rdata), .err(err)
   );

   data_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(16), .WAIT_CYCLES(0)) dut0 (
      .CLK(clk), .Reset(rst0_n), .req(req0), .we(we), .byteop(byteop), .addr(addr),
      .wdata(wdata), .ack(ack0), .rdata(rdata0), .err(err0)
   );

   // Transaction-level model: a request accepted at edge k completes at edge k+W,
   // and the next one may be accepted no earlier than edge k+W+2.
   int unsigned edge_n = 0, done_edge = 0, next_ok = 0;
   bit          pending = 0, exp_ack = 0, exp_err = 0, rd_known = 0, chk_en = 0;
   logic [31:0] exp_rdata = '0;
   bit          p_we, p_byte;
   logic [31:0] p_addr, p_wdata;
   logic [31:0] mm [int];

   function automatic void complete();
      logic [31:0] offset;
      int          idx, sh;
      bit          bad;
      offset = p_addr - BASE;
      idx    = int'(offset / 4);
      sh     = 8 * int'(p_addr % 4);
      bad    = (longint'(offset) >= 4 * longint'(MW)) || (!p_byte && (p_addr % 4 != 0));
      exp_ack = 1;
      exp_err = bad;
      if (bad) begin
         exp_rdata = '0;
         rd_known  = 1;
      end else if (p_we) begin
         if (!p_byte) mm[idx] = p_wdata;
         else if (mm.exists(idx))
            mm[idx] = (mm[idx] & ~(32'hFF << sh)) | ({24'd0, p_wdata[7:0]} << sh);
      end else if (mm.exists(idx)) begin
         exp_rdata = p_byte ? ((mm[idx] >> sh) & 32'hFF) : mm[idx];
         rd_known  = 1;
      end else begin
         rd_known = 0;
      end
   endfunction

   always @(posedge clk) begin
      edge_n++;
      exp_ack = 0;
      if (!rst_n) begin
         pending   = 0;
         exp_err   = 0;
         exp_rdata = '0;
         rd_known  = 1;
         next_ok   = edge_n + 1;
         chk_en    = 1;
      end else begin
         if (!pending && edge_n >= next_ok && req) begin
            p_we = we; p_byte = byteop; p_addr = addr; p_wdata = wdata;
            pending   = 1;
            done_edge = edge_n + W;
            next_ok   = edge_n + W + 2;
         end
         if (pending && edge_n == done_edge) begin
            pending = 0;
            complete();
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if (ack !== exp_ack) begin
            fails++;
            $display("FAIL model_ack edge %0d: got %b expected %b", edge_n, ack, exp_ack);
         end
         if (exp_ack) begin
            tests++;
            if (err !== exp_err) begin
               fails++;
               $display("FAIL model_err edge %0d: got %b expected %b", edge_n, err, exp_err);
            end
         end
         if (rd_known) begin
            tests++;
            if (rdata !== exp_rdata) begin
               fails++;
               $display("FAIL model_rdata edge %0d: got %h expected %h", edge_n, rdata,
                        exp_rdata);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Issues one request on the W=2 instance; lat counts edges from acceptance to ack.
   task automatic transact(input bit w, input bit b, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic e, output int lat);
      @(negedge clk);
      req = 1; we = w; byteop = b; addr = a; wdata = d;
      rd = '0; e = 0;
      @(negedge clk);
      req = 0; we = 1'($urandom); byteop = 1'($urandom); addr = $urandom; wdata = $urandom;
      lat = 1;
      while (!ack && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (ack) begin
         rd = rdata;
         e  = err;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        e;
      int          lat, nacks, last;
      rst_n = 0; rst0_n = 0; req = 1; req0 = 0; we = 1; byteop = 0;
      addr = BASE; wdata = 32'h0BAD_0BAD;
      repeat (3) @(negedge clk);
      check("reset_ack", {31'd0, ack}, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      req = 0; rst_n = 1; rst0_n = 1;

      for (int k = 0; k < 12; k++)
         transact(1, 0, BASE + 4 * ((k < 8) ? k : 1012 + k), $urandom, rd, e, lat);

      transact(1, 0, 32'h400, 32'hDEADBEEF, rd, e, lat);
      check("store_latency", lat, 3);
      check("store_err", {31'd0, e}, 0);
      transact(0, 0, 32'h400, 32'h0, rd, e, lat);
      check("load_latency", lat, 3);
      check("load_rdata", rd, 32'hDEADBEEF);
      check("load_err", {31'd0, e}, 0);

      transact(1, 0, 32'h400, 32'h11223344, rd, e, lat);
      transact(1, 1, 32'h402, 32'hFFFF_FF5A, rd, e, lat);
      transact(0, 0, 32'h400, 32'h0, rd, e, lat);
      check("byte_merge", rd, 32'h115A3344);
      transact(0, 1, 32'h402, 32'h0, rd, e, lat);
      check("byte_load", rd, 32'h0000005A);

      transact(0, 0, 32'h3FC, 32'h0, rd, e, lat);
      check("below_base_err", {31'd0, e}, 1);
      check("below_base_rdata", rd, 0);
      transact(0, 0, 32'h1400, 32'h0, rd, e, lat);
      check("above_top_err", {31'd0, e}, 1);
      check("above_top_rdata", rd, 0);
      transact(0, 0, 32'h13FC, 32'h0, rd, e, lat);
      check("last_word_err", {31'd0, e}, 0);
      transact(1, 0, 32'h401, 32'h55555555, rd, e, lat);
      check("misaligned_err", {31'd0, e}, 1);
      transact(0, 0, 32'h400, 32'h0, rd, e, lat);
      check("misaligned_no_write", rd, 32'h115A3344);

      transact(1, 0, 32'h404, 32'hCAFEF00D, rd, e, lat);
      @(negedge clk);
      req = 1; we = 1; byteop = 0; addr = 32'h404; wdata = 32'h12345678;
      @(negedge clk);
      req = 0; rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      nacks = 0;
      repeat (5) begin
         @(negedge clk);
         nacks += int'(ack);
      end
      check("abort_no_ack", nacks, 0);
      transact(0, 0, 32'h404, 32'h0, rd, e, lat);
      check("abort_latency", lat, 3);
      check("abort_no_write", rd, 32'hCAFEF00D);

      // req held high: acks every W+2 cycles
      @(negedge clk);
      req = 1; we = 0; byteop = 0; addr = 32'h400;
      nacks = 0; last = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (ack) begin
            if (nacks > 0) check("held_spacing", n - last, W + 2);
            nacks++;
            last = n;
         end
      end
      check("held_count", nacks, 5);
      req = 0;
      repeat (6) @(negedge clk);

      for (int t = 0; t < 300; t++) begin
         logic [31:0] a;
         int          k;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         k = $urandom_range(0, 11);
         case ($urandom_range(0, 9))
            7:       a = 32'h3FC + ($urandom & 3);
            8:       a = 32'h1400 + ($urandom & 7);
            9:       a = $urandom;
            default: a = BASE + 4 * ((k < 8) ? k : 1012 + k) + ($urandom & 3);
         endcase
         transact(1'($urandom), 1'($urandom), a, $urandom, rd, e, lat);
         if (lat >= 20) check("random_timeout", lat, W + 1);
      end

      // Zero-wait instance: held req gives ack on every other cycle.
      @(negedge clk);
      req0 = 1; we = 1; byteop = 0; addr = 32'h408; wdata = 32'hA5A5_1234;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         check("w0_ack_pattern", {31'd0, ack0}, n % 2);
         if (ack0) check("w0_err", {31'd0, err0}, 0);
      end
      req0 = 0;
      repeat (3) @(negedge clk);
      req0 = 1; we = 0;
      @(negedge clk);
      req0 = 0;
      check("w0_load_ack", {31'd0, ack0}, 1);
      check("w0_load_rdata", rdata0, 32'hA5A5_1234);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
